cp0_exc: RTL

Coprocessor-0 and exception sequencer. It consumes the trap and privilege signals produced by the instruction decoder (`exc_ri`, `exc_sys`, `exc_ret`, `cowrite`) and owns the privileged state: Status, Cause, EPC and Count. It drives `cpu_mode` back to the decoder, and drives the flush/redirect request to the fetch and pipeline stages. It sits beside the EX stage of the core.

---
 rtl/cp0_exc_pkg.sv | 15 +
 rtl/cp0_regs.sv | 62 ++++++
 rtl/cp0_exc.sv | 68 ++++++
 3 files changed

// File: rtl/cp0_exc_pkg.sv
// cp0_exc_pkg: CP0 register numbers, exception codes, sequencer states and Status bit indices
package cp0_exc_pkg;
  localparam logic [4:0] CP0_COUNT  = 5'd9;
  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;
  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_RI  = 5'd10;
  localparam int ST_MODE  = 0;
  localparam int ST_IE    = 1;
  localparam int ST_PMODE = 2;
  localparam int ST_PIE   = 3;
  typedef enum logic [1:0] {RUN = 2'd0, TRAP = 2'd1, RET = 2'd2} state_t;
endpackage

// File: rtl/cp0_regs.sv
// cp0_regs: Count/Status/Cause/EPC storage, write decode and read mux; irq sampling under CP0_IRQ_EN
module cp0_regs
  import cp0_exc_pkg::*;
#(
  parameter logic RESET_MODE = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trap,
  input  logic [4:0]  code,
  input  logic        ret,
  input  logic        wr_en,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
`ifdef CP0_IRQ_EN
  input  logic        irq,
  output logic        ie,
  output logic        ip,
`endif
  output logic [31:0] rdata,
  output logic        mode,
  output logic [31:0] epc
);
  logic [31:0] count;
  logic [3:0]  status;
  logic [4:0]  exccode;
  logic        ip_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      status  <= {3'b000, RESET_MODE};
      exccode <= '0;
      epc     <= '0;
    end else begin
      count <= (wr_en && addr == CP0_COUNT) ? wdata : count + 32'd1;
      if (trap) begin
        epc     <= pc;
        exccode <= code;
        status  <= {status[ST_IE], status[ST_MODE], 1'b0, 1'b1};
      end else if (ret) begin
        status[ST_IE:ST_MODE] <= status[ST_PIE:ST_PMODE];
      end else if (wr_en) begin
        if (addr == CP0_STATUS) status <= wdata[3:0];
        if (addr == CP0_EPC) epc <= wdata;
      end
    end
  end
`ifdef CP0_IRQ_EN
  always_ff @(posedge clk) ip_q <= reset ? 1'b0 : irq;
  assign ie = status[ST_IE];
  assign ip = ip_q;
`else
  assign ip_q = 1'b0;
`endif
  assign mode = status[ST_MODE];
  always_comb
    rdata = addr == CP0_COUNT  ? count :
            addr == CP0_STATUS ? {28'd0, status} :
            addr == CP0_CAUSE  ? {21'd0, ip_q, 3'd0, exccode, 2'd0} :
            addr == CP0_EPC    ? epc : 32'd0;
endmodule

// File: rtl/cp0_exc.sv
// cp0_exc: CP0 exception sequencer (RUN/TRAP/RET); interrupts enabled by CP0_IRQ_EN
module cp0_exc
  import cp0_exc_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080,
  parameter logic        RESET_MODE = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        exc_ri,
  input  logic        exc_sys,
  input  logic        exc_ret,
  input  logic        cowrite,
  input  logic [31:0] pc_ex,
  input  logic [4:0]  co_addr,
  input  logic [31:0] co_wdata,
`ifdef CP0_IRQ_EN
  input  logic        irq,
`endif
  output logic [31:0] co_rdata,
  output logic        cpu_mode,
  output logic        flush,
  output logic        redirect,
  output logic [31:0] redirect_pc
);
  state_t      state, state_n;
  logic        accept, take_int, trap, ret, wr;
  logic [4:0]  code;
  logic [31:0] epc;
`ifdef CP0_IRQ_EN
  logic ie, ip;
  assign take_int = accept && !(exc_ri || exc_sys || exc_ret || cowrite) && ip && ie;
`else
  assign take_int = 1'b0;
`endif
  assign accept = state == RUN && !stall;
  assign trap   = accept && (exc_ri || exc_sys || take_int);
  assign ret    = accept && !exc_ri && !exc_sys && exc_ret;
  assign wr     = accept && !exc_ri && !exc_sys && !exc_ret && cowrite;
  assign code   = exc_ri ? EXC_RI : exc_sys ? EXC_SYS : EXC_INT;
  always_ff @(posedge clk) state <= reset ? RUN : state_n;
  always_comb begin
    state_n     = trap ? TRAP : ret ? RET : RUN;
    flush       = state != RUN;
    redirect    = state != RUN;
    redirect_pc = state == TRAP ? EXC_VECTOR : state == RET ? epc : 32'd0;
  end
  cp0_regs #(.RESET_MODE(RESET_MODE)) u_regs (
    .clk   (clk),
    .reset (reset),
    .trap  (trap),
    .code  (code),
    .ret   (ret),
    .wr_en (wr),
    .addr  (co_addr),
    .wdata (co_wdata),
    .pc    (pc_ex),
`ifdef CP0_IRQ_EN
    .irq   (irq),
    .ie    (ie),
    .ip    (ip),
`endif
    .rdata (co_rdata),
    .mode  (cpu_mode),
    .epc   (epc)
  );
endmodule
